// File: rtl/alu_arbiter.sv
// Two-requester arbiter and sequencer in front of the shared W-bit ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int W        = 16,
  parameter int MUL_WAIT = 1,
  parameter int DIV_WAIT = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [W-1:0] alu_input1,
  output logic [W-1:0] alu_input2,
  output logic [3:0]   alu_opcode,
  input  logic [W-1:0] alu_out,
  output logic         busy
);

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_MULT = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t       r_state;
  logic         r_id;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_rsp_data;
  logic         r_rsp_err;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [3:0]   r_alu_op;

  logic         w_grant1;
  logic         w_accept;
  logic [3:0]   w_op;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [3:0]   w_wait;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'd9) && (op <= 4'd14);
  endfunction

  function automatic logic [3:0] wait_for(input logic [3:0] op);
    logic [3:0] n;
    n = 4'd0;
    if (op == OP_MULT) n = 4'(MUL_WAIT);
    else if (op == OP_DIV) n = 4'(DIV_WAIT);
    return n;
  endfunction

`ifdef ALU_ARB_RR_EN
  logic r_rr_ptr;

  // The pointer's requester wins a tie; after a grant the other side is preferred.
  always_comb begin
    w_grant1 = req1_valid;
    if (req0_valid && req1_valid) w_grant1 = r_rr_ptr;
  end

  always_ff @(posedge clk) begin
    if (clear) r_rr_ptr <= 1'b0;
    else if (w_accept) r_rr_ptr <= ~w_grant1;
  end
`else
  assign w_grant1 = ~req0_valid;
`endif

  assign w_accept   = (r_state == S_IDLE) && !clear && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grant1;
  assign req1_ready = w_accept && w_grant1;

  assign w_op   = w_grant1 ? req1_op : req0_op;
  assign w_a    = w_grant1 ? req1_a  : req0_a;
  assign w_b    = w_grant1 ? req1_b  : req0_b;
  assign w_wait = wait_for(r_alu_op);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_id       <= 1'b0;
      r_cnt      <= 4'd0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= OP_NOOP;
    end else begin
      case (r_state)
        // Accept: ALU inputs are loaded here so the ALU sees them throughout ISSUE.
        S_IDLE: begin
          if (w_accept) begin
            r_id <= w_grant1;
            if (is_illegal(w_op)) begin
              r_state    <= S_RESP;
              r_rsp_err  <= 1'b1;
              r_rsp_data <= '0;
            end else begin
              r_state  <= S_ISSUE;
              r_alu_a  <= w_a;
              r_alu_b  <= w_b;
              r_alu_op <= w_op;
            end
          end
        end
        S_ISSUE: begin
          if (w_wait == 4'd0) begin
            r_state    <= S_RESP;
            r_rsp_data <= alu_out;
            r_rsp_err  <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= OP_NOOP;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= w_wait;
          end
        end
        // Wait: inputs held; the last counted cycle captures the result.
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state    <= S_RESP;
            r_cnt      <= 4'd0;
            r_rsp_data <= alu_out;
            r_rsp_err  <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= OP_NOOP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign rsp_id     = r_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign alu_input1 = r_alu_a;
  assign alu_input2 = r_alu_b;
  assign alu_opcode = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clear;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0] rsp_data, alu_input1, alu_input2, alu_out;
  logic [3:0]   alu_opcode;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .MUL_WAIT(1), .DIV_WAIT(3)) dut (
    .clk(clk), .clear(clear),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .busy(busy)
  );

  // Behavioural ALU; divide by zero yields all ones.
  always_comb begin
    case (alu_opcode)
      4'd1: alu_out = alu_input1 + alu_input2;
      4'd2: alu_out = alu_input1 - alu_input2;
      4'd3: alu_out = alu_input1 * alu_input2;
      4'd4: alu_out = (alu_input2 == '0) ? 16'hFFFF : alu_input1 / alu_input2;
      4'd5: alu_out = alu_input1 & alu_input2;
      4'd6: alu_out = alu_input1 | alu_input2;
      4'd7: alu_out = alu_input1 ^ alu_input2;
      4'd8: alu_out = ~alu_input1;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic         rq;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd0; req1_op = 4'd0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  // Issue one request from an idle arbiter and follow it to the response handshake.
  task automatic run_op(input vec_t v, input int idx);
    int  lat;
    int  nalu;
    bit  got;
    rsp_ready = 1'b1;
    if (v.rq) begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end else begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end
    #3;
    chk($sformatf("v%0d.ready0", idx), 32'(req0_ready), 32'(!v.rq));
    chk($sformatf("v%0d.ready1", idx), 32'(req1_ready), 32'(v.rq));
    lat = 0; nalu = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #3;
      lat++;
      if (rsp_valid) got = 1'b1;
      else if (v.err ? (alu_opcode != 4'd0) : (alu_opcode == v.op)) nalu++;
    end
    chk($sformatf("v%0d.rsp_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d.data", idx), 32'(rsp_data), 32'(v.exp));
    chk($sformatf("v%0d.id", idx), 32'(rsp_id), 32'(v.rq));
    chk($sformatf("v%0d.err", idx), 32'(rsp_err), 32'(v.err));
    chk($sformatf("v%0d.alu_cycles", idx), 32'(nalu), v.err ? 32'd0 : 32'(v.lat - 1));
    if (v.err) chk($sformatf("v%0d.alu_noop", idx), 32'(alu_opcode), 32'd0);
    tick();
    #3;
    chk($sformatf("v%0d.rsp_drop", idx), 32'(rsp_valid), 32'd0);
    chk($sformatf("v%0d.idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    bit   got;
    int   nr;
    int   last;
    logic exp_ids[4];
    vec_t v;

    vecs[0]  = '{1'b0, 4'd1,  16'd1,     16'd1,     16'd2,     1'b0, 2};
    vecs[1]  = '{1'b1, 4'd4,  16'd8,     16'd2,     16'd4,     1'b0, 5};
    vecs[2]  = '{1'b0, 4'd2,  16'd3,     16'd1,     16'd2,     1'b0, 2};
    vecs[3]  = '{1'b1, 4'd7,  16'd11,    16'd13,    16'd6,     1'b0, 2};
    vecs[4]  = '{1'b0, 4'd3,  16'd300,   16'd300,   16'd24464, 1'b0, 3};
    vecs[5]  = '{1'b0, 4'd5,  16'hF0F0,  16'hFF00,  16'hF000,  1'b0, 2};
    vecs[6]  = '{1'b1, 4'd6,  16'h00F0,  16'h0F00,  16'h0FF0,  1'b0, 2};
    vecs[7]  = '{1'b0, 4'd8,  16'h00FF,  16'h1234,  16'hFF00,  1'b0, 2};
    vecs[8]  = '{1'b0, 4'd10, 16'd5,     16'd6,     16'd0,     1'b1, 1};
    vecs[9]  = '{1'b1, 4'd14, 16'd7,     16'd7,     16'd0,     1'b1, 1};
    vecs[10] = '{1'b0, 4'd2,  16'd0,     16'd1,     16'hFFFF,  1'b0, 2};
    vecs[11] = '{1'b1, 4'd1,  16'hFFFF,  16'd2,     16'd1,     1'b0, 2};
    vecs[12] = '{1'b0, 4'd4,  16'd5,     16'd0,     16'hFFFF,  1'b0, 5};
    vecs[13] = '{1'b0, 4'd9,  16'd1,     16'd1,     16'd0,     1'b1, 1};
    vecs[14] = '{1'b1, 4'd0,  16'd5,     16'd5,     16'd0,     1'b0, 2};

    idle_inputs();
    rsp_ready = 1'b0;
    clear = 1'b1;
    tick(); tick();
    clear = 1'b0;
    #3;
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("reset.rsp_id_err", 32'({rsp_id, rsp_err}), 32'd0);
    chk("reset.rsp_data", 32'(rsp_data), 32'd0);
    chk("reset.alu_in", 32'({alu_input1, alu_input2}), 32'd0);
    chk("reset.alu_op", 32'(alu_opcode), 32'd0);
    tick();

    for (int i = 0; i < 15; i++) run_op(vecs[i], i);

    // Both requesters held valid: arbitration order and 3-cycle throughput.
`ifdef ALU_ARB_RR_EN
    exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
`else
    exp_ids[0] = 1'b0; exp_ids[1] = 1'b0; exp_ids[2] = 1'b0; exp_ids[3] = 1'b0;
`endif
    clear = 1'b1; tick(); clear = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'd3;  req0_b = 16'd1;
    req1_valid = 1'b1; req1_op = 4'd7; req1_a = 16'd11; req1_b = 16'd13;
    nr = 0; last = -1;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      #3;
      if (rsp_valid) begin
        chk($sformatf("both.id%0d", nr), 32'(rsp_id), 32'(exp_ids[nr]));
        chk($sformatf("both.data%0d", nr), 32'(rsp_data), exp_ids[nr] ? 32'd6 : 32'd2);
        if (nr > 0) chk($sformatf("both.period%0d", nr), 32'(c - last), 32'd3);
        last = c;
        nr++;
      end
      tick();
    end
    idle_inputs();
    chk("both.count", 32'(nr), 32'd4);
    tick();

    // MULT response held while the consumer stalls; no new grants meanwhile.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 16'd2; req0_b = 16'd2;
    #3;
    chk("stall.accept", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 16'd1; req1_b = 16'd1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #3;
      if (rsp_valid) got = 1'b1;
      else tick();
    end
    chk("stall.rsp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stall.valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall.data%0d", k), 32'(rsp_data), 32'd4);
      chk($sformatf("stall.noready%0d", k), 32'({req0_ready, req1_ready}), 32'd0);
      tick();
      #3;
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall.last_noready", 32'({req0_ready, req1_ready}), 32'd0);
    tick();
    #3;
    chk("stall.next_grant", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    #3;
    chk("stall.next_data", 32'(rsp_data), 32'd2);
    chk("stall.next_id", 32'(rsp_id), 32'd1);
    tick();
    #3;
    chk("stall.idle", 32'(busy), 32'd0);
    idle_inputs();

    // Abort a DIV during its wait phase.
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 16'd8; req1_b = 16'd2;
    #3;
    chk("abort.accept", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    #3;
    chk("abort.in_wait", 32'(alu_opcode), 32'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #3;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort.alu_op", 32'(alu_opcode), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) got = 1'b1;
      tick();
      #3;
    end
    chk("abort.no_rsp", 32'(got), 32'd0);
    tick();
    v = '{1'b0, 4'd1, 16'd1, 16'd1, 16'd2, 1'b0, 2};
    run_op(v, 99);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
